// File: rtl/mac3_seq_pkg.sv
// Shared types and constants for the mac3 control sequencer.
// The tag channel width matches the default job counter width.
package mac3_seq_pkg;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_FINISH
   } mac3_seq_state_t;

   localparam int unsigned MAC3_PIPE_DEPTH   = 4;
   localparam int unsigned MAC3_DRAIN_BEATS  = 3;
   localparam int unsigned MAC3_TAG_CH_WIDTH = 16;

   typedef struct packed {
      logic                         last;
      logic [MAC3_TAG_CH_WIDTH-1:0] ch;
   } mac3_tag_t;
endpackage

// File: rtl/mac3_tag_pipe.sv
// Enable-gated {last, ch} shadow of the MAC pipeline.
// It advances only on issued beats, so it stays aligned with the MAC stages.
module mac3_tag_pipe
   import mac3_seq_pkg::*;
(
   input  logic                         clk,
   input  logic                         arst_n_in,
   input  logic                         en,
   input  logic                         tag_last_in,
   input  logic [MAC3_TAG_CH_WIDTH-1:0] tag_ch_in,
   output logic                         s3_last,
   output logic [MAC3_TAG_CH_WIDTH-1:0] s4_ch
);
   // Stage 4 keeps only the channel; its last flag is consumed as it enters.
   mac3_tag_t                    stage_q [MAC3_PIPE_DEPTH-1];
   mac3_tag_t                    stage_d [MAC3_PIPE_DEPTH-1];
   logic [MAC3_TAG_CH_WIDTH-1:0] ch4_q;
   logic [MAC3_TAG_CH_WIDTH-1:0] ch4_d;

   always_comb begin
      stage_d = stage_q;
      ch4_d   = ch4_q;
      if (en) begin
         stage_d[0] = '{last: tag_last_in, ch: tag_ch_in};
         for (int unsigned i = 1; i < MAC3_PIPE_DEPTH - 1; i++) begin
            stage_d[i] = stage_q[i-1];
         end
         ch4_d = stage_q[MAC3_PIPE_DEPTH-2].ch;
      end
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         for (int unsigned i = 0; i < MAC3_PIPE_DEPTH - 1; i++) begin
            stage_q[i] <= '0;
         end
         ch4_q <= '0;
      end else begin
         stage_q <= stage_d;
         ch4_q   <= ch4_d;
      end
   end

   assign s3_last = stage_q[MAC3_PIPE_DEPTH-2].last;
   assign s4_ch   = ch4_q;
endmodule

// File: rtl/mac3_sequencer.sv
// Job sequencer for one mac3 pipelined MAC: gates operand beats, issues
// drain beats and hands each finished sum to the output memory.
module mac3_sequencer
   import mac3_seq_pkg::*;
#(
   parameter int unsigned A_WIDTH           = 16,
   parameter int unsigned B_WIDTH           = 16,
   parameter int unsigned ACCUMULATOR_WIDTH = 32,
   parameter int unsigned OUTPUT_WIDTH      = 16,
   parameter int unsigned CNT_WIDTH         = 16
) (
   input  logic                         clk,
   input  logic                         arst_n_in,
   input  logic                         start,
   input  logic [CNT_WIDTH-1:0]         num_outputs,
   input  logic [CNT_WIDTH-1:0]         beats_per_output,
   output logic                         busy,
   output logic                         done,
   input  logic                         op_valid,
   output logic                         op_ready,
   input  logic [A_WIDTH-1:0]           op_a0,
   input  logic [A_WIDTH-1:0]           op_a1,
   input  logic [A_WIDTH-1:0]           op_a2,
   input  logic [B_WIDTH-1:0]           op_b0,
   input  logic [B_WIDTH-1:0]           op_b1,
   input  logic [B_WIDTH-1:0]           op_b2,
   input  logic [ACCUMULATOR_WIDTH-1:0] op_psum,
   output logic                         mac_input_valid,
   output logic                         mac_accumulate,
   output logic [A_WIDTH-1:0]           mac_a0,
   output logic [A_WIDTH-1:0]           mac_a1,
   output logic [A_WIDTH-1:0]           mac_a2,
   output logic [B_WIDTH-1:0]           mac_b0,
   output logic [B_WIDTH-1:0]           mac_b1,
   output logic [B_WIDTH-1:0]           mac_b2,
   output logic [ACCUMULATOR_WIDTH-1:0] mac_psum,
   output logic [31:0]                  mac_ch,
   input  logic [OUTPUT_WIDTH-1:0]      mac_out,
   output logic                         wr_valid,
   input  logic                         wr_ready,
   output logic [OUTPUT_WIDTH-1:0]      wr_data,
   output logic [CNT_WIDTH-1:0]         wr_ch
);
   mac3_seq_state_t      state_q, state_d;
   logic [CNT_WIDTH-1:0] nout_q, nout_d, bpo_q, bpo_d;
   logic [CNT_WIDTH-1:0] beat_q, beat_d, out_q, out_d;
   logic [1:0]           drain_q, drain_d;
   logic                 busy_q, busy_d, done_q, done_d, wr_valid_q, wr_valid_d;

   logic                         wr_stall, issue, run_issue;
   logic                         first_beat, last_beat, last_out;
   logic                         tag_last_in, s3_last;
   logic [MAC3_TAG_CH_WIDTH-1:0] tag_ch_in, s4_ch;

   always_comb begin
      state_d    = state_q;
      nout_d     = nout_q;
      bpo_d      = bpo_q;
      beat_d     = beat_q;
      out_d      = out_q;
      drain_d    = drain_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      wr_stall   = wr_valid_q && !wr_ready;
      issue      = ((state_q == ST_RUN && op_valid) || state_q == ST_DRAIN) && !wr_stall;
      run_issue  = issue && (state_q == ST_RUN);
      first_beat = (beat_q == '0);
      last_beat  = (beat_q == bpo_q - CNT_WIDTH'(1));
      last_out   = (out_q == nout_q - CNT_WIDTH'(1));

      tag_last_in = (state_q == ST_RUN) && last_beat;
      tag_ch_in   = (state_q == ST_RUN) ? MAC3_TAG_CH_WIDTH'(out_q) : '0;

      // The last tag entering stage 4 means the sum lands in the accumulator at this edge.
      if (issue && s3_last) begin
         wr_valid_d = 1'b1;
      end else if (wr_ready) begin
         wr_valid_d = 1'b0;
      end else begin
         wr_valid_d = wr_valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               nout_d  = num_outputs;
               bpo_d   = (beats_per_output == '0) ? CNT_WIDTH'(1) : beats_per_output;
               beat_d  = '0;
               out_d   = '0;
               busy_d  = 1'b1;
               state_d = (num_outputs == '0) ? ST_FINISH : ST_RUN;
            end
         end
         ST_RUN: begin
            if (issue) begin
               if (last_beat) begin
                  beat_d = '0;
                  if (last_out) begin
                     drain_d = '0;
                     state_d = ST_DRAIN;
                  end else begin
                     out_d = out_q + CNT_WIDTH'(1);
                  end
               end else begin
                  beat_d = beat_q + CNT_WIDTH'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (issue) begin
               drain_d = drain_q + 2'd1;
               if (drain_q == 2'(MAC3_DRAIN_BEATS - 1)) begin
                  state_d = ST_FINISH;
               end
            end
         end
         ST_FINISH: begin
            if (!wr_valid_q || wr_ready) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q    <= ST_IDLE;
         nout_q     <= '0;
         bpo_q      <= '0;
         beat_q     <= '0;
         out_q      <= '0;
         drain_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         nout_q     <= nout_d;
         bpo_q      <= bpo_d;
         beat_q     <= beat_d;
         out_q      <= out_d;
         drain_q    <= drain_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_valid_q <= wr_valid_d;
      end
   end

   mac3_tag_pipe u_tag_pipe (
      .clk         (clk),
      .arst_n_in   (arst_n_in),
      .en          (issue),
      .tag_last_in (tag_last_in),
      .tag_ch_in   (tag_ch_in),
      .s3_last     (s3_last),
      .s4_ch       (s4_ch)
   );

   assign busy            = busy_q;
   assign done            = done_q;
   assign wr_valid        = wr_valid_q;
   assign op_ready        = (state_q == ST_RUN) && !wr_stall;
   assign mac_input_valid = issue;
   assign mac_accumulate  = issue && (state_q == ST_DRAIN || !first_beat);
   assign mac_a0          = run_issue ? op_a0 : '0;
   assign mac_a1          = run_issue ? op_a1 : '0;
   assign mac_a2          = run_issue ? op_a2 : '0;
   assign mac_b0          = run_issue ? op_b0 : '0;
   assign mac_b1          = run_issue ? op_b1 : '0;
   assign mac_b2          = run_issue ? op_b2 : '0;
   assign mac_psum        = (run_issue && first_beat) ? op_psum : '0;
   assign mac_ch          = run_issue ? 32'(out_q) : '0;
   assign wr_data         = mac_out;
   assign wr_ch           = CNT_WIDTH'(s4_ch);
endmodule
